// File: rtl/serial_negate_word_if.sv
// Serial word stream bundle: source-side bit/frame/mode inputs and result outputs.
interface serial_negate_word_if;
  logic in_valid;
  logic in_bit;
  logic in_sow;
  logic neg;
  logic out_valid;
  logic out_bit;
  logic out_sow;
  logic out_eow;
  logic trunc;
  logic ovf;

  modport master (
    output in_valid, in_bit, in_sow, neg,
    input  out_valid, out_bit, out_sow, out_eow, trunc, ovf
  );

  modport slave (
    input  in_valid, in_bit, in_sow, neg,
    output out_valid, out_bit, out_sow, out_eow, trunc, ovf
  );
endinterface

// File: rtl/serial_negate_word.sv
// Word-framed LSB-first serial negate/pass unit with registered outputs.
// Define SERIAL_NEG_OVF_EN to include the most-negative overflow detector.
module serial_negate_word #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_negate_word_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    INVERT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            vld_q, vld_d;
  logic            bit_q, bit_d;
  logic            sow_q, sow_d;
  logic            eow_q, eow_d;
  logic            trunc_q, trunc_d;
  logic            ovf_q, ovf_d;

  logic            acc_sow;
  logic            acc_mid;
  logic            last;

  assign acc_sow = bus.in_valid & bus.in_sow;
  assign acc_mid = bus.in_valid & ~bus.in_sow
                 & (state_q != IDLE);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
      bit_q   <= 1'b0;
      sow_q   <= 1'b0;
      eow_q   <= 1'b0;
      trunc_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      vld_q   <= vld_d;
      bit_q   <= bit_d;
      sow_q   <= sow_d;
      eow_q   <= eow_d;
      trunc_q <= trunc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    vld_d   = 1'b0;
    bit_d   = 1'b0;
    sow_d   = 1'b0;
    eow_d   = 1'b0;
    trunc_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (1'b1)
      acc_sow: begin
        // a start bit always opens a fresh word; bit 0 is never inverted
        neg_d   = bus.neg;
        cnt_d   = CW'(1);
        state_d = bus.in_bit ? INVERT : COPY;
        vld_d   = 1'b1;
        bit_d   = bus.in_bit;
        sow_d   = 1'b1;
        trunc_d = (state_q != IDLE);
      end
      acc_mid: begin
        vld_d = 1'b1;
        bit_d = bus.in_bit
              ^ (neg_q & (state_q == INVERT));
`ifdef SERIAL_NEG_OVF_EN
        ovf_d = last & neg_q & bus.in_bit
              & (state_q == COPY);
`endif
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          eow_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == COPY && bus.in_bit)
            state_d = INVERT;
        end
      end
      default: ;
    endcase
  end

  assign bus.out_valid = vld_q;
  assign bus.out_bit   = bit_q;
  assign bus.out_sow   = sow_q;
  assign bus.out_eow   = eow_q;
  assign bus.trunc     = trunc_q;
  assign bus.ovf       = ovf_q;

endmodule
